// File: rtl/dmem_scrub_arbiter.sv
// dmem_scrub_arbiter
// Background ECC scrubber and CPU/scrub port arbiter for the Hamming-protected
// data memory. CPU accesses always win the memory port. In otherwise idle
// cycles the scrubber reads one word every INTERVAL+1 cycles. It writes back
// words that had a single-bit correction. It counts corrected and
// uncorrectable words, and pulses an interrupt for each uncorrectable word.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   scrub_en          enable background scrubbing
//   cnt_clr           synchronous clear of both error counters
//   cpu_req/WE/A/WD   CPU load/store port (byte address)
//   mem_A/WD/WE       memory port (word-addressed by A[AW+1:2])
//   mem_RD            corrected read data, combinational on mem_A
//   mem_s_err/d_err   single/double error flags for mem_A
//   scrub_busy        scrubber owns the address (READ or WB)
//   pass_done         one-cycle pulse when the scrub index wraps
//   corr_cnt          saturating count of corrected words written back
//   uncorr_cnt        saturating count of uncorrectable words found
//   uncorr_addr       byte address of the latest uncorrectable word
//   uncorr_irq        one-cycle pulse per uncorrectable detection
module dmem_scrub_arbiter #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned INTERVAL = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scrub_en,
  input  logic             cnt_clr,
  input  logic             cpu_req,
  input  logic             cpu_WE,
  input  logic [31:0]      cpu_A,
  input  logic [31:0]      cpu_WD,
  output logic [31:0]      mem_A,
  output logic [31:0]      mem_WD,
  output logic             mem_WE,
  input  logic [31:0]      mem_RD,
  input  logic             mem_s_err,
  input  logic             mem_d_err,
  output logic             scrub_busy,
  output logic             pass_done,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  output logic [31:0]      uncorr_addr,
  output logic             uncorr_irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(INTERVAL - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, READ, WB} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [31:0]   wb_data, wb_data_nx;
  logic          corr_inc, uncorr_inc, advance;
  logic [31:0]   scrub_addr;
  logic          idx_hit;
  logic          we_raw;

  assign scrub_addr = {{(30 - AW){1'b0}}, idx, 2'b00};
  assign idx_hit    = (cpu_A[AW+1:2] == idx);
  assign scrub_busy = (state == READ) || (state == WB);

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    wcnt_nx    = wcnt;
    wb_data_nx = wb_data;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (scrub_en) begin
          state_nx = WAIT;
          wcnt_nx  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (!scrub_en)          state_nx = IDLE;
        else if (wcnt == '0)    state_nx = READ;
        else                    wcnt_nx  = wcnt - 1'b1;
      end
      READ: begin
        // Disable takes precedence: leave without sampling, idx held.
        if (!scrub_en) begin
          state_nx = IDLE;
        end else if (!cpu_req) begin
          if (mem_d_err) begin
            uncorr_inc = 1'b1;
            advance    = 1'b1;
          end else if (mem_s_err) begin
            wb_data_nx = mem_RD;
            state_nx   = WB;
          end else begin
            advance = 1'b1;
          end
        end
      end
      WB: begin
        // A CPU store to the same word supersedes the write-back; the
        // correction is still counted since the upset was found.
        if (!cpu_req || (cpu_WE && idx_hit)) begin
          corr_inc = 1'b1;
          advance  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (advance) begin
      idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      state_nx = WAIT;
      wcnt_nx  = WAIT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      wcnt        <= '0;
      wb_data     <= '0;
      pass_done   <= 1'b0;
      uncorr_irq  <= 1'b0;
      uncorr_addr <= '0;
      corr_cnt    <= '0;
      uncorr_cnt  <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      wcnt       <= wcnt_nx;
      wb_data    <= wb_data_nx;
      pass_done  <= advance && (idx == IDX_LAST);
      uncorr_irq <= uncorr_inc;
      if (uncorr_inc) uncorr_addr <= scrub_addr;
      if (cnt_clr) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
      end else begin
        if (corr_inc && (corr_cnt != '1))     corr_cnt   <= corr_cnt + 1'b1;
        if (uncorr_inc && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end

  // Port mux: CPU has absolute priority; the scrubber only drives the
  // address in READ and the full write port in WB.
  always_comb begin
    mem_A  = cpu_A;
    mem_WD = cpu_WD;
    we_raw = 1'b0;
    if (cpu_req) begin
      we_raw = cpu_WE;
    end else if (state == READ) begin
      mem_A = scrub_addr;
    end else if (state == WB) begin
      mem_A  = scrub_addr;
      mem_WD = wb_data;
      we_raw = 1'b1;
    end
    mem_WE = we_raw & rst;
  end

endmodule

// File: tb/tb_dmem_scrub_arbiter.sv
// Self-checking bench for dmem_scrub_arbiter (DEPTH=16, INTERVAL=4, CNT_W=3).
// A behavioural memory with per-word error state sits on the memory port;
// a reference model tracks the scrubber as "active / cycles left before the
// next read / write-back pending" and predicts every output each cycle.
module tb_dmem_scrub_arbiter;
  localparam int DEPTH    = 16;
  localparam int INTERVAL = 4;
  localparam int CNT_W    = 3;
  localparam int AW       = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic scrub_en = 1'b0, cnt_clr = 1'b0, cpu_req = 1'b0, cpu_WE = 1'b0;
  logic [31:0] cpu_A = '0, cpu_WD = '0;
  logic [31:0] mem_A, mem_WD, mem_RD, uncorr_addr;
  logic mem_WE, mem_s_err, mem_d_err, scrub_busy, pass_done, uncorr_irq;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

  // behavioural memory: true data plus error state (0 clean, 1 single, 2 double)
  logic [31:0] mem_data [DEPTH];
  int          mem_err  [DEPTH];

  assign mem_RD    = mem_data[mem_A[AW+1:2]];
  assign mem_s_err = (mem_err[mem_A[AW+1:2]] == 1);
  assign mem_d_err = (mem_err[mem_A[AW+1:2]] == 2);

  dmem_scrub_arbiter #(.DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .cnt_clr(cnt_clr),
    .cpu_req(cpu_req), .cpu_WE(cpu_WE), .cpu_A(cpu_A), .cpu_WD(cpu_WD),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .mem_s_err(mem_s_err), .mem_d_err(mem_d_err), .scrub_busy(scrub_busy),
    .pass_done(pass_done), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .uncorr_addr(uncorr_addr), .uncorr_irq(uncorr_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, pd_cnt = 0, pd_last = -1, pd_period = 0, irq_cnt = 0;

  // reference model
  bit          m_on, m_pend, m_pd, m_irq;
  int          m_gap, m_idx, m_corr, m_uncorr;
  logic [31:0] m_wb, m_uaddr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pend = 0; m_pd = 0; m_irq = 0;
    m_gap = 0; m_idx = 0; m_corr = 0; m_uncorr = 0;
    m_wb = '0; m_uaddr = '0;
  endtask

  task automatic model_step(input bit req, input bit we, input logic [31:0] a,
                            input bit en, input bit clr);
    bit ic, iu, adv;
    ic = 0; iu = 0; adv = 0; m_pd = 0; m_irq = 0;
    if (m_pend) begin
      if (!req || (we && (a[AW+1:2] == m_idx))) begin
        ic = 1; adv = 1; m_pend = 0;
      end
    end else if (!m_on) begin
      if (en) begin m_on = 1; m_gap = INTERVAL; end
    end else if (!en) begin
      m_on = 0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (!req) begin
      if (mem_err[m_idx] == 2) begin
        iu = 1; m_irq = 1; m_uaddr = 32'(m_idx * 4); adv = 1;
      end else if (mem_err[m_idx] == 1) begin
        m_wb = mem_data[m_idx]; m_pend = 1;
      end else begin
        adv = 1;
      end
    end
    if (adv) begin
      m_pd  = (m_idx == DEPTH - 1);
      m_idx = (m_idx + 1) % DEPTH;
      m_gap = INTERVAL;
    end
    if (clr) begin
      m_corr = 0; m_uncorr = 0;
    end else begin
      if (ic && m_corr < CMAX)   m_corr++;
      if (iu && m_uncorr < CMAX) m_uncorr++;
    end
  endtask

  task automatic cycle(input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit en, input bit clr);
    bit busy_e, we_e;
    logic [31:0] a_e;
    logic w_en;
    logic [31:0] w_a, w_d;
    @(negedge clk);
    cpu_req = req; cpu_WE = we; cpu_A = a; cpu_WD = wd; scrub_en = en; cnt_clr = clr;
    #1;
    busy_e = m_pend || (m_on && m_gap == 0);
    a_e    = req ? a : (busy_e ? 32'(m_idx * 4) : a);
    we_e   = req ? we : m_pend;
    check("mem_A", mem_A, a_e);
    check("mem_WE", 32'(mem_WE), 32'(we_e));
    if (we_e) check("mem_WD", mem_WD, req ? wd : m_wb);
    check("scrub_busy", 32'(scrub_busy), 32'(busy_e));
    check("pass_done", 32'(pass_done), 32'(m_pd));
    check("uncorr_irq", 32'(uncorr_irq), 32'(m_irq));
    check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
    check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
    check("uncorr_addr", uncorr_addr, m_uaddr);
    if (pass_done === 1'b1) begin
      if (pd_last >= 0) pd_period = cyc - pd_last;
      pd_last = cyc;
      pd_cnt++;
    end
    if (uncorr_irq === 1'b1) irq_cnt++;
    model_step(req, we, a, en, clr);
    w_en = mem_WE; w_a = mem_A; w_d = mem_WD;
    @(posedge clk);
    #1;
    if (w_en === 1'b1) begin
      mem_data[w_a[AW+1:2]] = w_d;
      mem_err[w_a[AW+1:2]]  = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
  endtask

  task automatic wait_read(input int bound);
    int k = 0;
    while (!(m_on && m_gap == 0 && !m_pend) && k < bound) begin idle(1); k++; end
    if (k >= bound) check("wait_read_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pend(input int bound);
    int k = 0;
    while (!m_pend && k < bound) begin idle(1); k++; end
    if (k >= bound) check("wait_wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_WE = 1'b1; cpu_A = 32'h8; cpu_WD = $urandom; scrub_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_mem_WE", 32'(mem_WE), 32'd0);
    check("rst_busy", 32'(scrub_busy), 32'd0);
    check("rst_pass_done", 32'(pass_done), 32'd0);
    check("rst_irq", 32'(uncorr_irq), 32'd0);
    check("rst_corr", 32'(corr_cnt), 32'd0);
    check("rst_uncorr", 32'(uncorr_cnt), 32'd0);
    check("rst_uaddr", uncorr_addr, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    // scrub_en low so no unmodelled edge moves the scrubber out of IDLE
    cpu_req = 1'b0; cpu_WE = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
    #2 rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin mem_data[i] = $urandom; mem_err[i] = 0; end
    model_reset();
    do_reset();

    // clean memory: no writes, pass every DEPTH*(INTERVAL+1) cycles
    idle(170);
    check("pass_pulses", 32'(pd_cnt), 32'd2);
    check("pass_period", 32'(pd_period), 32'd80);
    check("clean_corr", 32'(corr_cnt), 32'd0);

    // single upset on word 3, double on word 5
    mem_err[3] = 1; mem_err[5] = 2; irq_cnt = 0;
    idle(90);
    check("w3_corr", 32'(corr_cnt), 32'd1);
    check("w5_uncorr", 32'(uncorr_cnt), 32'd1);
    check("w5_addr", uncorr_addr, 32'h14);
    check("w5_irq_pulses", 32'(irq_cnt), 32'd1);
    check("w3_scrubbed", 32'(mem_err[3]), 32'd0);
    check("w5_untouched", 32'(mem_err[5]), 32'd2);
    mem_err[5] = 0;

    // CPU holds the port for 10 cycles while the scrubber is in READ
    wait_read(10);
    repeat (10) cycle(1'b1, 1'b0, $urandom & 32'h3c, $urandom, 1'b1, 1'b0);
    idle(1);

    // CPU store to the word being written back supersedes it
    mem_err[m_idx] = 1;
    wait_pend(10);
    w = m_idx;
    v = 32'hCAFE_0000 | 32'(w);
    cycle(1'b1, 1'b1, 32'(w * 4), v, 1'b1, 1'b0);
    idle(1);
    check("abandon_data", mem_data[w], v);
    check("abandon_err", 32'(mem_err[w]), 32'd0);
    check("abandon_corr", 32'(corr_cnt), 32'd2);

    // saturation
    for (int i = 0; i < DEPTH; i++) mem_err[i] = 1;
    idle(DEPTH * (INTERVAL + 2) + 10);
    check("corr_saturated", 32'(corr_cnt), 32'(CMAX));

    // clear coincides with an increment
    mem_err[m_idx] = 1;
    wait_pend(10);
    cycle(1'b0, 1'b0, $urandom, $urandom, 1'b1, 1'b1);
    check("clr_wins", 32'(corr_cnt), 32'd0);

    // reset during write-back: write lost, index restarts at 0
    idle(3);
    mem_err[m_idx] = 1;
    wait_pend(10);
    do_reset();
    idle(12);

    // randomized traffic, injections, enables and clears
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 19) == 0)
        mem_err[$urandom_range(0, DEPTH - 1)] = int'($urandom_range(1, 2));
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, $urandom,
            $urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0);
      if (n == 1250) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
